// File: rtl/pipo_shift_reg.sv
// pipo_shift_reg: parallel-in, parallel-out register chain.
// Every rising edge loads a WIDTH-bit word into stage 0 and shifts the chain,
// so a word sampled on pi appears on po DEPTH edges later. A saturating fill
// counter raises po_valid once the chain holds only post-reset data.
module pipo_shift_reg #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active-low
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] po,
    output logic             po_valid
);

    // A chain of zero stages would have no output register to drive po.
    if (DEPTH < 1) begin : g_bad_depth
        $error("pipo_shift_reg: DEPTH must be >= 1 (got %0d)", DEPTH);
    end

    localparam int                CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [CNT_W-1:0] fill_cnt;

    // Shift chain: load pi into stage 0 and move every word one stage along.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value; blocking here would collapse
    // the chain into a single stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: each stage is a real flop (not a RAM), so clearing every
            // entry on reset is cheap and keeps po at 0 until real data arrives.
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= pi;
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    // Fill counter: count load edges since reset, holding at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt <= '0;
        end else if (fill_cnt != FULL) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    assign po       = stage[DEPTH-1];
    assign po_valid = (fill_cnt == FULL);

endmodule

// File: tb/tb_pipo_shift_reg.sv
// tb_pipo_shift_reg: self-checking bench for pipo_shift_reg.
// Two instances share clk and rst: DEPTH=1/WIDTH=4 and DEPTH=3/WIDTH=8.
// Expected values come from constant tables, hand sequences, and a
// history-queue model of "po shows the word sampled DEPTH edges ago".
module tb_pipo_shift_reg;

    logic       clk;
    logic       rst;
    logic [3:0] pi1;
    logic [3:0] po1;
    logic       v1;
    logic [7:0] pi3;
    logic [7:0] po3;
    logic       v3;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: words sampled since reset, and number of load edges.
    logic [3:0] hist1 [$];
    logic [7:0] hist3 [$];
    int         n_edges;

    typedef struct {
        logic [7:0] pi;
        logic [7:0] exp_po;
        logic       exp_valid;
    } vec_t;

    vec_t tbl1 [$];
    vec_t tbl3 [$];

    pipo_shift_reg #(.WIDTH(4), .DEPTH(1)) u_d1 (
        .clk      (clk),
        .rst      (rst),
        .pi       (pi1),
        .po       (po1),
        .po_valid (v1)
    );

    pipo_shift_reg #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clk      (clk),
        .rst      (rst),
        .pi       (pi3),
        .po       (po3),
        .po_valid (v3)
    );

    // Period 10 ns, rising edges at 10, 20, 30 ...
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist1.delete();
        hist3.delete();
        n_edges = 0;
    endtask

    // One rising edge: update the model, then settle 1 ns past the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            hist1.push_back(pi1);
            hist3.push_back(pi3);
            if (hist1.size() > 4) void'(hist1.pop_front());
            if (hist3.size() > 4) void'(hist3.pop_front());
            n_edges++;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] e1;
        logic [7:0] e3;
        e1 = (n_edges >= 1) ? hist1[hist1.size()-1] : 4'h0;
        e3 = (n_edges >= 3) ? hist3[hist3.size()-3] : 8'h00;
        check({tag, "_po1"}, 32'(po1), 32'(e1));
        check({tag, "_v1"},  32'(v1),  32'(n_edges >= 1));
        check({tag, "_po3"}, 32'(po3), 32'(e3));
        check({tag, "_v3"},  32'(v3),  32'(n_edges >= 3));
    endtask

    initial begin
        // DEPTH=1: count 0..9, then alternating / extreme patterns.
        for (int i = 0; i < 10; i++) tbl1.push_back('{8'(i), 8'(i), 1'b1});
        tbl1.push_back('{8'hA, 8'hA, 1'b1});
        tbl1.push_back('{8'h5, 8'h5, 1'b1});
        tbl1.push_back('{8'hF, 8'hF, 1'b1});
        tbl1.push_back('{8'h0, 8'h0, 1'b1});
        // DEPTH=3: three-edge latency, valid after the third edge.
        tbl3.push_back('{8'h11, 8'h00, 1'b0});
        tbl3.push_back('{8'h22, 8'h00, 1'b0});
        tbl3.push_back('{8'h33, 8'h11, 1'b1});
        tbl3.push_back('{8'h44, 8'h22, 1'b1});
        tbl3.push_back('{8'h00, 8'h33, 1'b1});
        tbl3.push_back('{8'h00, 8'h44, 1'b1});

        // Reset held with pi toggling: outputs stay cleared.
        rst = 1'b0;
        pi1 = 4'hF;
        pi3 = 8'hFF;
        model_reset();
        #1;
        check("rst_po1", 32'(po1), 32'h0);
        check("rst_v1",  32'(v1),  32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_po1", 32'(po1), 32'h0);
            check("rst_hold_v1",  32'(v1),  32'h0);
            check("rst_hold_po3", 32'(po3), 32'h0);
            pi1 = ~pi1;
            pi3 = ~pi3;
        end

        // Release between edges: first edge loads pi.
        pi1 = 4'hF;
        #3 rst = 1'b1;
        tick();
        check("rel_po1", 32'(po1), 32'hF);
        check("rel_v1",  32'(v1),  32'h1);
        check("rel_v3",  32'(v3),  32'h0);

        // Sequential load with release 1 ns before an edge.
        rst = 1'b0;
        model_reset();
        tick();
        pi1 = 4'h0;
        #8 rst = 1'b1;
        foreach (tbl1[i]) begin
            pi1 = tbl1[i].pi[3:0];
            tick();
            check($sformatf("tbl1_po[%0d]", i), 32'(po1), 32'(tbl1[i].exp_po[3:0]));
            check($sformatf("tbl1_v[%0d]", i),  32'(v1),  32'(tbl1[i].exp_valid));
        end

        // Constant input: po steady at edges and mid-cycle.
        pi1 = 4'h9;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_po1_edge", 32'(po1), 32'h9);
            #4;
            check("hold_po1_mid", 32'(po1), 32'h9);
        end

        // Asynchronous reset mid-stream clears before the next edge.
        pi1 = 4'h7;
        tick();
        check("mid_pre_po1", 32'(po1), 32'h7);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("mid_rst_po1", 32'(po1), 32'h0);
        check("mid_rst_v1",  32'(v1),  32'h0);
        check("mid_rst_po3", 32'(po3), 32'h0);
        check("mid_rst_v3",  32'(v3),  32'h0);
        #1 rst = 1'b1;
        pi1 = 4'hC;
        tick();
        check("mid_resume_po1", 32'(po1), 32'hC);
        check("mid_resume_v1",  32'(v1),  32'h1);

        // DEPTH=3 latency and fill flag after a fresh reset.
        #2 rst = 1'b0;
        model_reset();
        #1 rst = 1'b1;
        foreach (tbl3[i]) begin
            pi3 = tbl3[i].pi;
            tick();
            check($sformatf("tbl3_po[%0d]", i), 32'(po3), 32'(tbl3[i].exp_po));
            check($sformatf("tbl3_v[%0d]", i),  32'(v3),  32'(tbl3[i].exp_valid));
        end

        // Random traffic with occasional mid-cycle resets against the model.
        for (int i = 0; i < 250; i++) begin
            pi1 = 4'($urandom);
            pi3 = 8'($urandom);
            tick();
            check_model("rnd");
            if ($urandom_range(0, 29) == 0) begin
                #2 rst = 1'b0;
                model_reset();
                #1;
                check_model("rnd_rst");
                #1 rst = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
